// File: rtl/axis_pkt_arbiter_if.sv
// ---------------------------------------------------------------------------
// axis_pkt_arbiter_if
//
// Minimal AXI-Stream bundle used by axis_pkt_arbiter for its two source
// ports and its single output port.
//
// Signals:
//   tdata   DATA_WIDTH  payload
//   tvalid  1           beat valid
//   tlast   1           last beat of packet
//   tready  1           sink ready
//
// Modports:
//   master  drives tdata/tvalid/tlast, receives tready (the arbiter output)
//   slave   receives tdata/tvalid/tlast, drives tready (the arbiter inputs)
// ---------------------------------------------------------------------------
interface axis_pkt_arbiter_if #(
    parameter int DATA_WIDTH = 64
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/axis_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// axis_pkt_arbiter
//
// Packet-granular round-robin arbiter sharing one AXI-Stream path to the DMA
// between two sources (port 0: sample data, port 1: events/status). A grant
// is held for a whole packet so beats of different packets never interleave.
// The output is a single registered stage. A watchdog bounds packet length
// to MAX_BEATS beats by forcing tlast and releasing the grant.
//
// Parameters:
//   DATA_WIDTH     stream data width in bits
//   MAX_BEATS      packet length limit in beats (>= 2)
//
// Ports:
//   clk            stream clock
//   rstn           synchronous, active-low reset
//   port_enable    bit n allows port n to win arbitration (looked at in IDLE)
//   s0_axis        source port 0 (slave modport)
//   s1_axis        source port 1 (slave modport)
//   m_axis         registered output towards the DMA (master modport)
//   owner          one-hot current grant, 2'b00 while idle
//   pkt_count0/1   packets forwarded per port, wrapping 16-bit counters
//   beat_overflow  sticky flag, set when the watchdog truncates a packet
// ---------------------------------------------------------------------------
module axis_pkt_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS  = 4096
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [1:0]                port_enable,
    axis_pkt_arbiter_if.slave         s0_axis,
    axis_pkt_arbiter_if.slave         s1_axis,
    axis_pkt_arbiter_if.master        m_axis,
    output logic [1:0]                owner,
    output logic [15:0]               pkt_count0,
    output logic [15:0]               pkt_count1,
    output logic                      beat_overflow
);

    // Counter only needs to reach MAX_BEATS-1; the watchdog ends the packet
    // there, so the counter is never asked to hold MAX_BEATS itself.
    localparam int               CNT_W     = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    state_t                  state_q,         state_d;
    logic                    last_grant_q,    last_grant_d;
    logic [CNT_W-1:0]        beat_cnt_q,      beat_cnt_d;
    logic [DATA_WIDTH-1:0]   m_tdata_q,       m_tdata_d;
    logic                    m_tvalid_q,      m_tvalid_d;
    logic                    m_tlast_q,       m_tlast_d;
    logic [15:0]             pkt_count0_q,    pkt_count0_d;
    logic [15:0]             pkt_count1_q,    pkt_count1_d;
    logic                    beat_overflow_q, beat_overflow_d;

    // -----------------------------------------------------------------------
    // Per-port view of the two source interfaces
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   src_data [2];
    logic [1:0]              src_valid;
    logic [1:0]              src_last;
    logic [1:0]              src_ready;
    logic [1:0]              req;
    logic [1:0]              acc;
    logic [1:0]              grant;
    logic                    out_free;

    assign src_data[0]  = s0_axis.tdata;
    assign src_data[1]  = s1_axis.tdata;
    assign src_valid[0] = s0_axis.tvalid;
    assign src_valid[1] = s1_axis.tvalid;
    assign src_last[0]  = s0_axis.tlast;
    assign src_last[1]  = s1_axis.tlast;

    assign s0_axis.tready = src_ready[0];
    assign s1_axis.tready = src_ready[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        // A disabled port never requests, but an already granted port is
        // served to the end of its packet regardless of its enable bit.
        assign req[gi]       = src_valid[gi] && port_enable[gi];
        // Ready depends only on registered state and m_axis.tready, never on
        // the source's own tvalid.
        assign src_ready[gi] = grant[gi] && out_free;
        assign acc[gi]       = src_valid[gi] && src_ready[gi];
    end

    // -----------------------------------------------------------------------
    // Beat selection and packet-end detection
    // -----------------------------------------------------------------------
    logic                  acc_any;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  watchdog;
    logic                  eop;

    always_comb begin
        acc_any  = |acc;
        sel_last = grant[1] ? src_last[1] : src_last[0];
        sel_data = grant[1] ? src_data[1] : src_data[0];
        // The MAX_BEATS-th beat of a packet without tlast closes the packet.
        watchdog = acc_any && (beat_cnt_q == LAST_BEAT) && !sel_last;
        eop      = acc_any && (sel_last || watchdog);
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req == 2'b11) begin
                    // Tie goes to the port that did not win last time.
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                end else if (req[0]) begin
                    state_d = GRANT0;
                end else if (req[1]) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        grant    = 2'b00;
        out_free = !m_tvalid_q || m_axis.tready;
        unique case (state_q)
            GRANT0:  grant = 2'b01;
            GRANT1:  grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath, counters and flags
    // -----------------------------------------------------------------------
    always_comb begin
        m_tdata_d       = m_tdata_q;
        m_tvalid_d      = m_tvalid_q;
        m_tlast_d       = m_tlast_q;
        last_grant_d    = last_grant_q;
        beat_cnt_d      = beat_cnt_q;
        pkt_count0_d    = pkt_count0_q;
        pkt_count1_d    = pkt_count1_q;
        beat_overflow_d = beat_overflow_q;

        // Output register: load on accept, drain when the sink takes the
        // beat and nothing replaces it. tdata is left holding its last value.
        if (acc_any) begin
            m_tdata_d  = sel_data;
            m_tvalid_d = 1'b1;
            m_tlast_d  = sel_last || watchdog;
        end else if (m_axis.tready) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end

        // Counter is held at zero in IDLE so every grant starts from zero.
        if (state_q == IDLE) begin
            beat_cnt_d = '0;
        end else if (acc_any) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end

        if (state_q == IDLE && req == 2'b11) begin
            last_grant_d = (state_d == GRANT1);
        end

        if (eop) begin
            last_grant_d = grant[1];
            if (grant[0]) begin
                pkt_count0_d = pkt_count0_q + 16'd1;
            end else begin
                pkt_count1_d = pkt_count1_q + 16'd1;
            end
        end

        if (watchdog) begin
            beat_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant_q    <= 1'b1;
            beat_cnt_q      <= '0;
            m_tdata_q       <= '0;
            m_tvalid_q      <= 1'b0;
            m_tlast_q       <= 1'b0;
            pkt_count0_q    <= 16'd0;
            pkt_count1_q    <= 16'd0;
            beat_overflow_q <= 1'b0;
        end else begin
            last_grant_q    <= last_grant_d;
            beat_cnt_q      <= beat_cnt_d;
            m_tdata_q       <= m_tdata_d;
            m_tvalid_q      <= m_tvalid_d;
            m_tlast_q       <= m_tlast_d;
            pkt_count0_q    <= pkt_count0_d;
            pkt_count1_q    <= pkt_count1_d;
            beat_overflow_q <= beat_overflow_d;
        end
    end

    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;
    assign owner         = grant;
    assign pkt_count0    = pkt_count0_q;
    assign pkt_count1    = pkt_count1_q;
    assign beat_overflow = beat_overflow_q;

endmodule
